uart_mm_arbiter: RTL and testbench

UART_MM_ARBITER -- requirements
Module: uart_mm_arbiter

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/uart_arb_slot.sv | 40 ++++
 rtl/uart_mm_arbiter.sv | 171 +++++++++++++++++
 tb/tb_uart_mm_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART DMA-to-slave arbiter.
// Optional round-robin arbitration is selected with ARB_ROUND_ROBIN_EN.
package uart_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } slot_t;

endpackage

// File: rtl/uart_arb_slot.sv
// One-deep pending command slot for a single DMA master.
// Holds the command stable until the arbiter reports acceptance.
module uart_arb_slot
    import uart_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    input  logic              clear,
    output slot_t             q,
    output logic              overrun,
    output logic              waitrequest
);

    logic pulse;

    assign pulse       = write | read;
    assign overrun     = pulse & q.valid;
    assign waitrequest = q.valid & q.wr & ~clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (q.valid) begin
            if (clear) begin
                q.valid <= 1'b0;
            end
        end else if (pulse) begin
            // write wins when both strobes arrive together
            q.valid <= 1'b1;
            q.wr    <= write;
            q.addr  <= address;
            q.data  <= writedata;
        end
    end

endmodule

// File: rtl/uart_mm_arbiter.sv
// Two-master arbiter sharing one Avalon-MM slave between UART DMAs.
// Define ARB_ROUND_ROBIN_EN for alternating grant; default is m0 priority.
module uart_mm_arbiter
    import uart_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_write,
    input  logic              m0_read,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic              m1_write,
    input  logic              m1_read,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              avm_write,
    output logic              avm_read,
    output logic [ADDR_W-1:0] avm_address,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [1:0]        grant,
    output logic [1:0]        err
);

    localparam int CLOG = $clog2(TIMEOUT + 1);
    localparam int CW   = (CLOG > 8) ? CLOG : 8;

    state_t         state, state_n;
    logic           owner, owner_n;
    logic           last, last_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [1:0]     err_n;

    slot_t          s0, s1, cur;
    logic           ov0, ov1;
    logic           clear0, clear1;
    logic           accept;
    logic           pick;
    logic           issue;
    logic           expired;
    logic           rdv;
    logic [DATA_W-1:0] rdata;

    uart_arb_slot u_slot0 (
        .clk         (clk),
        .rst         (rst),
        .write       (m0_write),
        .read        (m0_read),
        .address     (m0_address),
        .writedata   (m0_writedata),
        .clear       (clear0),
        .q           (s0),
        .overrun     (ov0),
        .waitrequest (m0_waitrequest)
    );

    uart_arb_slot u_slot1 (
        .clk         (clk),
        .rst         (rst),
        .write       (m1_write),
        .read        (m1_read),
        .address     (m1_address),
        .writedata   (m1_writedata),
        .clear       (clear1),
        .q           (s1),
        .overrun     (ov1),
        .waitrequest (m1_waitrequest)
    );

    assign cur     = owner ? s1 : s0;
    assign issue   = (state == ISSUE) & cur.valid;
    assign accept  = issue & ~avm_waitrequest;
    assign clear0  = accept & ~owner;
    assign clear1  = accept & owner;
    assign expired = (cnt == CW'(TIMEOUT));

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        pick = 1'b0;
        unique case (1'b1)
            s0.valid & s1.valid: pick = ~last;
            s1.valid:            pick = 1'b1;
            default:             pick = 1'b0;
        endcase
    end
`else
    assign pick = ~s0.valid;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
            err   <= 2'b00;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            cnt   <= cnt_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        cnt_n   = cnt;
        err_n   = err | {1'b0, ov0 | ov1};
        unique case (state)
            IDLE: begin
                if (s0.valid | s1.valid) begin
                    owner_n = pick;
                    last_n  = pick;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    cnt_n   = '0;
                    state_n = cur.wr ? IDLE : RDWAIT;
                end
            end
            RDWAIT: begin
                if (avm_readdatavalid) begin
                    state_n = IDLE;
                end else if (expired) begin
                    err_n[1] = 1'b1;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign avm_write     = issue & cur.wr;
    assign avm_read      = issue & ~cur.wr;
    assign avm_address   = issue ? cur.addr : '0;
    assign avm_writedata = issue ? cur.data : '0;

    always_comb begin
        grant = 2'b00;
        if (state != IDLE) begin
            grant = owner ? 2'b10 : 2'b01;
        end
    end

    // real slave data wins over an abort landing on the same cycle
    assign rdv   = (state == RDWAIT) & (avm_readdatavalid | expired);
    assign rdata = avm_readdatavalid ? avm_readdata : TIMEOUT_FILL;

    assign m0_readdatavalid = rdv & ~owner;
    assign m1_readdatavalid = rdv & owner;
    assign m0_readdata      = m0_readdatavalid ? rdata : '0;
    assign m1_readdata      = m1_readdatavalid ? rdata : '0;

endmodule

// File: tb/tb_uart_mm_arbiter.sv
// Self-checking bench for uart_mm_arbiter with a transaction-level model.
// Honors ARB_ROUND_ROBIN_EN when predicting grant order.
module tb_uart_mm_arbiter;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_write, m0_read;
    logic [15:0] m0_address;
    logic [31:0] m0_writedata;
    logic        m0_waitrequest, m0_readdatavalid;
    logic [31:0] m0_readdata;
    logic        m1_write, m1_read;
    logic [15:0] m1_address;
    logic [31:0] m1_writedata;
    logic        m1_waitrequest, m1_readdatavalid;
    logic [31:0] m1_readdata;
    logic        avm_write, avm_read;
    logic [15:0] avm_address;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic [1:0]  grant, err;

    int n_chk  = 0;
    int n_fail = 0;
    int last_m = 1;

    always #5 clk = ~clk;

    uart_mm_arbiter #(.TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .m0_write          (m0_write),
        .m0_read           (m0_read),
        .m0_address        (m0_address),
        .m0_writedata      (m0_writedata),
        .m0_waitrequest    (m0_waitrequest),
        .m0_readdatavalid  (m0_readdatavalid),
        .m0_readdata       (m0_readdata),
        .m1_write          (m1_write),
        .m1_read           (m1_read),
        .m1_address        (m1_address),
        .m1_writedata      (m1_writedata),
        .m1_waitrequest    (m1_waitrequest),
        .m1_readdatavalid  (m1_readdatavalid),
        .m1_readdata       (m1_readdata),
        .avm_write         (avm_write),
        .avm_read          (avm_read),
        .avm_address       (avm_address),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_readdata      (avm_readdata),
        .grant             (grant),
        .err               (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model of the arbitration rule: who is granted given pending set.
    function automatic int arb(input bit p0, input bit p1);
        int g;
`ifdef ARB_ROUND_ROBIN_EN
        if (p0 && p1) g = (last_m == 1) ? 0 : 1;
        else          g = p0 ? 0 : 1;
`else
        g = p0 ? 0 : 1;
`endif
        last_m = g;
        return g;
    endfunction

    function automatic logic [63:0] ctl_out();
        return 64'({grant, err, avm_write, avm_read, avm_address,
                    avm_writedata, m0_waitrequest, m0_readdatavalid,
                    m1_waitrequest, m1_readdatavalid});
    endfunction

    task automatic pulse(input bit e0, input bit w0,
                         input logic [15:0] a0, input logic [31:0] d0,
                         input bit e1, input bit w1,
                         input logic [15:0] a1, input logic [31:0] d1);
        m0_write     = e0 & w0;
        m0_read      = e0 & ~w0;
        m0_address   = a0;
        m0_writedata = w0 ? d0 : 32'h0;
        m1_write     = e1 & w1;
        m1_read      = e1 & ~w1;
        m1_address   = a1;
        m1_writedata = w1 ? d1 : 32'h0;
        @(negedge clk);
        m0_write = 0; m0_read = 0;
        m1_write = 0; m1_read = 0;
    endtask

    task automatic serve(input int m, input bit wr,
                         input logic [15:0] a, input logic [31:0] d,
                         input int ws, input int lat,
                         input logic [31:0] rd, input bit no_resp);
        int k;
        int held;
        logic [63:0] exp_cmd;
        exp_cmd = 64'({wr, !wr, a, wr ? d : 32'h0});
        k = 0;
        while (!(avm_write || avm_read) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("issue_seen", 64'(k < 20), 64'(1));
        chk("avm_cmd", 64'({avm_write, avm_read, avm_address,
                            avm_writedata}), exp_cmd);
        chk("grant", 64'(grant), (m == 1) ? 64'(2) : 64'(1));
        if (wr) chk("m_wait_stall",
                    64'((m == 1) ? m1_waitrequest : m0_waitrequest), 64'(1));
        held = 0;
        for (int i = 0; i < ws; i++) begin
            if (64'({avm_write, avm_read, avm_address,
                     avm_writedata}) == exp_cmd) held++;
            @(negedge clk);
        end
        avm_waitrequest = 0;
        #1;
        if (64'({avm_write, avm_read, avm_address,
                 avm_writedata}) == exp_cmd) held++;
        chk("avm_held", 64'(held), 64'(ws + 1));
        if (wr) chk("m_wait_accept",
                    64'((m == 1) ? m1_waitrequest : m0_waitrequest), 64'(0));
        @(negedge clk);
        avm_waitrequest = 1;
        if (!wr && !no_resp) begin
            repeat (lat) @(negedge clk);
            avm_readdatavalid = 1;
            avm_readdata = rd;
            #1;
            chk("rd_route", 64'({m0_readdatavalid, m1_readdatavalid}),
                (m == 1) ? 64'(1) : 64'(2));
            chk("rd_data", 64'((m == 1) ? m1_readdata : m0_readdata), 64'(rd));
            chk("rd_other", 64'((m == 1) ? m0_readdata : m1_readdata), 64'(0));
            @(negedge clk);
            avm_readdatavalid = 0;
            avm_readdata = 0;
        end
    endtask

    task automatic do_reset();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        last_m = 1;
        @(negedge clk);
    endtask

    initial begin
        int f, s, k;
        bit e0, e1, w0, w1;
        logic [15:0] a0, a1;
        logic [31:0] d0, d1, r0, r1;

        rst = 0;
        m0_write = 0; m0_read = 0; m0_address = 0; m0_writedata = 0;
        m1_write = 0; m1_read = 0; m1_address = 0; m1_writedata = 0;
        avm_waitrequest = 1; avm_readdatavalid = 0; avm_readdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", ctl_out(), 64'(0));
        chk("rst_rdata", {m0_readdata, m1_readdata}, 64'(0));
        rst = 1;
        @(negedge clk);

        // simultaneous reads: m0 first in both arbitration modes
        pulse(1, 0, 16'h0004, 0, 1, 0, 16'h0008, 0);
        f = arb(1, 1);
        chk("sim_first_m0", 64'(f), 64'(0));
        serve(f, 0, f ? 16'h0008 : 16'h0004, 0, 0, 1,
              f ? 32'h22 : 32'h11, 0);
        s = arb(f == 1, f == 0);
        serve(s, 0, s ? 16'h0008 : 16'h0004, 0, 1, 2,
              s ? 32'h22 : 32'h11, 0);

        // stalled write, 3 waitrequest cycles
        pulse(1, 1, 16'h0010, 32'hA5A5A5A5, 0, 0, 0, 0);
        f = arb(1, 0);
        serve(f, 1, 16'h0010, 32'hA5A5A5A5, 3, 0, 0, 0);

        // two m1 reads, then a simultaneous request
        for (int i = 0; i < 2; i++) begin
            pulse(0, 0, 0, 0, 1, 0, 16'h0100 + 16'(i), 0);
            f = arb(0, 1);
            serve(f, 0, 16'h0100 + 16'(i), 0, 0, 0, 32'h5000 + 32'(i), 0);
        end
        pulse(1, 1, 16'h0200, 32'h1234, 1, 1, 16'h0300, 32'h5678);
        f = arb(1, 1);
        chk("alt_to_m0", 64'(f), 64'(0));
        serve(f, 1, f ? 16'h0300 : 16'h0200,
              f ? 32'h5678 : 32'h1234, 0, 0, 0, 0);
        s = arb(f == 1, f == 0);
        serve(s, 1, s ? 16'h0300 : 16'h0200,
              s ? 32'h5678 : 32'h1234, 0, 0, 0, 0);

        // overrun: second m0 pulse while its slot is full
        pulse(1, 1, 16'h0040, 32'hCAFE0001, 0, 0, 0, 0);
        pulse(1, 1, 16'h0044, 32'hCAFE0002, 0, 0, 0, 0);
        chk("overrun_err", 64'(err), 64'(1));
        f = arb(1, 0);
        serve(f, 1, 16'h0040, 32'hCAFE0001, 1, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("dropped", 64'({avm_write, avm_read, grant}), 64'(0));

        // randomized mixed traffic against the model
        for (int it = 0; it < 12; it++) begin
            e0 = 1'($urandom_range(0, 1));
            e1 = e0 ? 1'($urandom_range(0, 1)) : 1'b1;
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            a0 = 16'($urandom); a1 = 16'($urandom);
            d0 = $urandom; d1 = $urandom;
            r0 = $urandom; r1 = $urandom;
            pulse(e0, w0, a0, d0, e1, w1, a1, d1);
            f = arb(e0, e1);
            serve(f, f ? w1 : w0, f ? a1 : a0, f ? d1 : d0,
                  $urandom_range(0, 3), $urandom_range(0, 5),
                  f ? r1 : r0, 0);
            if (e0 && e1) begin
                s = arb(f == 1, f == 0);
                serve(s, s ? w1 : w0, s ? a1 : a0, s ? d1 : d0,
                      $urandom_range(0, 3), $urandom_range(0, 5),
                      s ? r1 : r0, 0);
            end
        end

        // read timeout
        do_reset();
        pulse(0, 0, 0, 0, 1, 0, 16'h0030, 0);
        f = arb(0, 1);
        serve(f, 0, 16'h0030, 0, 0, 0, 0, 1);
        k = 0;
        while (!m1_readdatavalid && k < TO + 40) begin
            @(negedge clk);
            k++;
        end
        chk("to_latency", 64'(k >= TO && k <= TO + 1), 64'(1));
        chk("to_data", 64'(m1_readdata), 64'(32'hFFFFFFFF));
        chk("to_m0", 64'({m0_readdatavalid, m0_readdata}), 64'(0));
        @(negedge clk);
        chk("to_err", 64'(err), 64'(2));
        chk("to_idle", 64'({grant, m1_readdatavalid}), 64'(0));

        // reset during ISSUE
        pulse(1, 1, 16'h0050, 32'hDEADBEEF, 0, 0, 0, 0);
        k = 0;
        while (!avm_write && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_issue_seen", 64'(k < 20), 64'(1));
        rst = 0;
        #1;
        chk("rst_async", 64'({avm_write, grant}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        chk("post_rst_ctl", ctl_out(), 64'(0));
        chk("post_rst_rd", {m0_readdata, m1_readdata}, 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
